// File: rtl/write_queued_if.sv
// Bundles the execute-side result bus, register file feedback and memory write port of write_queued.
interface write_queued_if #(
    parameter int DATA_W = 32,
    parameter int NR     = 32,
    parameter int DEPTH  = 4
);
    localparam int RW = $clog2(NR);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [RW-1:0]     dest_reg;
    logic [DATA_W-1:0] dest_value;
    logic              has_upper_value;
    logic [DATA_W-1:0] upper_value;
    logic              is_writing_memory;
    logic [DATA_W-1:0] adjustment;
    logic [3:0]        flags;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] next_pc;
    logic              has_flushed_in;
    logic [NR*DATA_W-1:0] input_registers;
    logic [NR*DATA_W-1:0] output_registers;
    logic              has_flushed;
    logic              hold;
    logic              address_enable;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic [CW-1:0]     queue_count;

    modport master (
        output in_valid, dest_reg, dest_value, has_upper_value, upper_value,
               is_writing_memory, adjustment, flags, pc_in, next_pc,
               has_flushed_in, input_registers, data_valid,
        input  output_registers, has_flushed, hold, address_enable,
               address, data, queue_count
    );

    modport slave (
        input  in_valid, dest_reg, dest_value, has_upper_value, upper_value,
               is_writing_memory, adjustment, flags, pc_in, next_pc,
               has_flushed_in, input_registers, data_valid,
        output output_registers, has_flushed, hold, address_enable,
               address, data, queue_count
    );
endinterface

// File: rtl/write_queued.sv
// Write-back stage: commits results to the register file and buffers stores in a FIFO
// that drains to memory one entry per accepted data_valid.
module write_queued #(
    parameter int DATA_W    = 32,
    parameter int NR        = 32,
    parameter int DEPTH     = 4,
    parameter int FLAGS_IDX = 1,
    parameter int PC_IDX    = NR - 1
) (
    input logic clock,
    input logic reset_n,
    write_queued_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [NR*DATA_W-1:0] regs;
    logic [NR*DATA_W-1:0] next_regs;
    logic                 flushed;
    logic [DATA_W-1:0]    addr_mem [DEPTH];
    logic [DATA_W-1:0]    data_mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 accept;
    logic [DATA_W-1:0]    base;
    int                   dest;

    assign dest   = int'(bus.dest_reg);
    assign full   = (count == (PW+1)'(DEPTH));
    assign pop    = (count != '0) && bus.data_valid;
    assign accept = bus.in_valid && !bus.hold;
    assign push   = accept && bus.is_writing_memory;

    assign bus.hold             = bus.in_valid && bus.is_writing_memory && full && !pop;
    assign bus.address_enable   = (count != '0);
    assign bus.address          = addr_mem[rd_ptr];
    assign bus.data             = data_mem[rd_ptr];
    assign bus.queue_count      = count;
    assign bus.output_registers = regs;
    assign bus.has_flushed      = flushed;

    // Store base: the PC slot reads as the fetch PC, r0 reads as zero.
    always_comb begin
        base = '0;
        if (dest == PC_IDX)
            base = bus.pc_in;
        else if (dest != 0)
            base = bus.input_registers[dest*DATA_W +: DATA_W];
    end

    // Destination writes override the flags merge; PC and r0 are applied last so they always win.
    always_comb begin
        next_regs = regs;
        if (accept) begin
            next_regs = bus.input_registers;
            next_regs[FLAGS_IDX*DATA_W+27 +: 4] = bus.flags;
            if (!bus.is_writing_memory) begin
                next_regs[dest*DATA_W +: DATA_W] = bus.dest_value;
                if (bus.has_upper_value && (dest + 1 < NR))
                    next_regs[(dest+1)*DATA_W +: DATA_W] = bus.upper_value;
            end
        end
        if (bus.in_valid && !bus.is_writing_memory && dest == PC_IDX)
            next_regs[PC_IDX*DATA_W +: DATA_W] = bus.dest_value;
        else
            next_regs[PC_IDX*DATA_W +: DATA_W] = bus.next_pc;
        next_regs[0 +: DATA_W] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs    <= '0;
            flushed <= 1'b0;
        end else begin
            regs <= next_regs;
            if (accept)
                flushed <= bus.has_flushed_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; pointers and count define which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= base + bus.adjustment;
            data_mem[wr_ptr] <= bus.dest_value;
        end
    end
endmodule

// File: tb/tb_write_queued.sv
// Self-checking bench for write_queued: directed vectors and sequences plus randomized traffic
// compared against a word-array/queue reference model.
module tb_write_queued;
    localparam int DW    = 32;
    localparam int NR    = 32;
    localparam int DEPTH = 4;
    localparam int FI    = 1;
    localparam int PCI   = NR - 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    typedef struct {
        logic [4:0]    dreg;
        logic [DW-1:0] base;
        logic [DW-1:0] pc;
        logic [DW-1:0] adj;
        logic [DW-1:0] dv;
        logic [DW-1:0] exp_addr;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] mregs [NR];
    logic          mflush;
    entry_t        mq [$];

    write_queued_if #(.DATA_W(DW), .NR(NR), .DEPTH(DEPTH)) bus ();

    write_queued #(.DATA_W(DW), .NR(NR), .DEPTH(DEPTH), .FLAGS_IDX(FI), .PC_IDX(PCI)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        int first;
        first = -1;
        for (int i = NR - 1; i >= 0; i--)
            if (bus.output_registers[i*DW +: DW] !== mregs[i]) first = i;
        total++;
        if (first >= 0) begin
            bad++;
            $display("[TB] FAIL %s r%0d actual=%0h expected=%0h", name, first,
                     bus.output_registers[first*DW +: DW], mregs[first]);
        end
    endtask

    function automatic logic [DW-1:0] in_reg(input int i);
        return bus.input_registers[i*DW +: DW];
    endfunction

    task automatic feed_model_regs();
        for (int i = 0; i < NR; i++) bus.input_registers[i*DW +: DW] = mregs[i];
    endtask

    task automatic set_idle();
        bus.in_valid          = 1'b0;
        bus.dest_reg          = '0;
        bus.dest_value        = '0;
        bus.has_upper_value   = 1'b0;
        bus.upper_value       = '0;
        bus.is_writing_memory = 1'b0;
        bus.adjustment        = '0;
        bus.flags             = '0;
        bus.pc_in             = '0;
        bus.next_pc           = mregs[PCI] + 32'd4;
        bus.has_flushed_in    = 1'b0;
        bus.data_valid        = 1'b0;
        reset_n               = 1'b1;
        feed_model_regs();
    endtask

    // One clock: predict from current inputs, clock, then compare every output with the model.
    task automatic apply_stimulus();
        logic          pop;
        logic          exp_hold;
        logic          acc;
        logic          st;
        int            d;
        logic [DW-1:0] nregs [NR];
        logic [DW-1:0] base;
        logic          nflush;
        #1;
        st       = bus.is_writing_memory;
        pop      = (mq.size() != 0) && bus.data_valid;
        exp_hold = bus.in_valid && st && (mq.size() == DEPTH) && !pop;
        check_output("hold", bus.hold, exp_hold);
        acc    = bus.in_valid && !exp_hold;
        d      = int'(bus.dest_reg);
        nregs  = mregs;
        nflush = mflush;
        if (acc) begin
            for (int i = 0; i < NR; i++) nregs[i] = in_reg(i);
            nregs[FI][30:27] = bus.flags;
            if (!st) begin
                nregs[d] = bus.dest_value;
                if (bus.has_upper_value && d + 1 < NR) nregs[d+1] = bus.upper_value;
            end
            nflush = bus.has_flushed_in;
        end
        nregs[PCI] = (bus.in_valid && !st && d == PCI) ? bus.dest_value : bus.next_pc;
        nregs[0]   = '0;
        base = (d == PCI) ? bus.pc_in : (d == 0) ? '0 : in_reg(d);
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) nregs[i] = '0;
            nflush = 1'b0;
            mq.delete();
        end else begin
            if (pop) mq.delete(0);
            if (acc && st) mq.push_back('{a: base + bus.adjustment, d: bus.dest_value});
        end
        @(posedge clock);
        #1;
        mregs  = nregs;
        mflush = nflush;
        check_regs("regs");
        check_output("has_flushed", bus.has_flushed, mflush);
        check_output("queue_count", bus.queue_count, mq.size());
        check_output("address_enable", bus.address_enable, mq.size() != 0);
        if (mq.size() != 0) begin
            check_output("address", bus.address, mq[0].a);
            check_output("data", bus.data, mq[0].d);
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        apply_stimulus();
        set_idle();
    endtask

    task automatic push_store(input logic [4:0] dreg, input logic [DW-1:0] adj,
                              input logic [DW-1:0] dv, input logic dvalid);
        set_idle();
        bus.in_valid          = 1'b1;
        bus.is_writing_memory = 1'b1;
        bus.dest_reg          = dreg;
        bus.adjustment        = adj;
        bus.dest_value        = dv;
        bus.data_valid        = dvalid;
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{dreg: 5'd3,  base: 32'h100,      pc: 32'h0,  adj: 32'h4,        dv: 32'hAA, exp_addr: 32'h104};
        vecs[1] = '{dreg: 5'd31, base: 32'hDEAD,     pc: 32'h40, adj: 32'hFFFFFFFC, dv: 32'h1,  exp_addr: 32'h3C};
        vecs[2] = '{dreg: 5'd0,  base: 32'h555,      pc: 32'h0,  adj: 32'h10,       dv: 32'h2,  exp_addr: 32'h10};
        vecs[3] = '{dreg: 5'd7,  base: 32'hFFFFFFF0, pc: 32'h0,  adj: 32'h20,       dv: 32'h3,  exp_addr: 32'h10};

        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mflush = 1'b0;
        do_reset();
        check_output("reset_count", bus.queue_count, 0);
        check_output("reset_enable", bus.address_enable, 0);
        check_output("reset_regs_zero", |bus.output_registers, 0);

        // Store address vectors, each from an empty queue.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push_store(vecs[v].dreg, vecs[v].adj, vecs[v].dv, 1'b0);
            bus.pc_in = vecs[v].pc;
            bus.input_registers[int'(vecs[v].dreg)*DW +: DW] = vecs[v].base;
            apply_stimulus();
            check_output($sformatf("vec%0d_address", v), bus.address, vecs[v].exp_addr);
            check_output($sformatf("vec%0d_data", v), bus.data, vecs[v].dv);
            check_output($sformatf("vec%0d_count", v), bus.queue_count, 1);
            check_output($sformatf("vec%0d_enable", v), bus.address_enable, 1);
        end

        // Fill the queue, stall the fifth store, then release it with a simultaneous pop.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            push_store(5'd0, 32'(k * 16), 32'(k), 1'b0);
            apply_stimulus();
        end
        check_output("full_count", bus.queue_count, 4);
        push_store(5'd0, 32'h50, 32'h5, 1'b0);
        #1;
        check_output("full_hold", bus.hold, 1);
        apply_stimulus();
        check_output("held_count", bus.queue_count, 4);
        check_output("held_head", bus.address, 32'h10);
        push_store(5'd0, 32'h50, 32'h5, 1'b1);
        #1;
        check_output("release_hold", bus.hold, 0);
        apply_stimulus();
        check_output("release_count", bus.queue_count, 4);
        check_output("release_head", bus.address, 32'h20);
        for (int k = 0; k < 4; k++) begin
            set_idle();
            bus.data_valid = 1'b1;
            apply_stimulus();
        end
        check_output("drain_count", bus.queue_count, 0);

        // Pair write, then pair write at the last index.
        set_idle();
        bus.in_valid = 1'b1; bus.dest_reg = 5'd4; bus.dest_value = 32'h11;
        bus.has_upper_value = 1'b1; bus.upper_value = 32'h22;
        apply_stimulus();
        check_output("pair_r4", bus.output_registers[4*DW +: DW], 32'h11);
        check_output("pair_r5", bus.output_registers[5*DW +: DW], 32'h22);
        set_idle();
        bus.in_valid = 1'b1; bus.dest_reg = 5'(NR - 1); bus.dest_value = 32'h77;
        bus.has_upper_value = 1'b1; bus.upper_value = 32'h99;
        apply_stimulus();
        check_output("pair_top", bus.output_registers[(NR-1)*DW +: DW], 32'h77);
        check_output("pair_r0", bus.output_registers[0 +: DW], 32'h0);

        // PC writes and free-running PC update.
        set_idle();
        bus.in_valid = 1'b1; bus.dest_reg = 5'(PCI); bus.dest_value = 32'h2000;
        apply_stimulus();
        check_output("pc_write", bus.output_registers[PCI*DW +: DW], 32'h2000);
        set_idle();
        bus.next_pc = 32'h2004;
        bus.input_registers[4*DW +: DW] = 32'hBAD;
        apply_stimulus();
        check_output("pc_next", bus.output_registers[PCI*DW +: DW], 32'h2004);
        check_output("idle_r4", bus.output_registers[4*DW +: DW], 32'h11);

        // Reset with stores pending discards them.
        for (int k = 1; k <= 3; k++) begin
            push_store(5'd0, 32'(k * 4), 32'(k), 1'b0);
            apply_stimulus();
        end
        check_output("pending_count", bus.queue_count, 3);
        do_reset();
        check_output("flush_count", bus.queue_count, 0);
        check_output("flush_enable", bus.address_enable, 0);
        check_output("flush_regs", |bus.output_registers, 0);
        set_idle();
        bus.data_valid = 1'b1;
        apply_stimulus();
        check_output("late_dv_count", bus.queue_count, 0);
        check_output("late_dv_enable", bus.address_enable, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            set_idle();
            for (int i = 0; i < NR; i++)
                if ($urandom_range(3) == 0) bus.input_registers[i*DW +: DW] = $urandom;
            bus.in_valid          = ($urandom_range(3) != 0);
            bus.is_writing_memory = $urandom_range(1);
            bus.dest_reg          = 5'($urandom_range(NR - 1));
            bus.dest_value        = $urandom;
            bus.has_upper_value   = $urandom_range(1);
            bus.upper_value       = $urandom;
            bus.adjustment        = $urandom;
            bus.flags             = 4'($urandom);
            bus.pc_in             = $urandom;
            bus.next_pc           = $urandom;
            bus.has_flushed_in    = $urandom_range(1);
            bus.data_valid        = ($urandom_range(2) == 0);
            reset_n               = ($urandom_range(60) != 0);
            apply_stimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
